// File: rtl/dmem_banked_if.sv
// Request/response bundle for the banked data memory: valid/ready request, pulsed response.
interface dmem_banked_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_strb;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_strb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_strb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_banked.sv
// Byte-addressed data memory built from NB byte-lane banks, registered read, range-error response.
// Define DMEM_MISALIGN_EN to build the two-beat misaligned path; otherwise misaligned requests error.
module dmem_banked #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_BYTES  = 4096,
  parameter int RD_PIPE    = 0
) (
  input logic          clk,
  input logic          rst_n,
  dmem_banked_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int WA    = ADDR_WIDTH - LB;
  localparam int DEPTH = MEM_BYTES / NB;
  localparam int DW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [NB-1:0]         strb_t;
  typedef logic [LB-1:0]         off_t;
  typedef logic [WA-1:0]         word_t;

  // Request byte j lands in bank (j + off) mod NB.
  function automatic data_t rotl_data(input data_t d, input off_t o);
    data_t r;
    off_t  s;
    for (int j = 0; j < NB; j++) begin
      s = off_t'(j) - o;
      r[j*8 +: 8] = d[int'(s)*8 +: 8];
    end
    return r;
  endfunction

  function automatic strb_t rotl_strb(input strb_t d, input off_t o);
    strb_t r;
    off_t  s;
    for (int j = 0; j < NB; j++) begin
      s = off_t'(j) - o;
      r[j] = d[int'(s)];
    end
    return r;
  endfunction

  function automatic data_t rotr_data(input data_t d, input off_t o);
    data_t r;
    off_t  s;
    for (int i = 0; i < NB; i++) begin
      s = off_t'(i) + o;
      r[i*8 +: 8] = d[int'(s)*8 +: 8];
    end
    return r;
  endfunction

  function automatic strb_t lanes_from(input off_t o);
    strb_t r;
    for (int j = 0; j < NB; j++) r[j] = (j >= int'(o));
    return r;
  endfunction

  off_t  req_off;
  word_t req_w;
  logic  req_oor, req_err, acc, split, beat2, rdy;
  data_t req_wdata_rot;
  strb_t req_strb_rot;

  assign req_off       = bus.req_addr[LB-1:0];
  assign req_w         = bus.req_addr[ADDR_WIDTH-1:LB];
  assign req_oor       = ({1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(NB-1)) >= (ADDR_WIDTH+1)'(MEM_BYTES);
  assign req_wdata_rot = rotl_data(bus.req_wdata, req_off);
  assign req_strb_rot  = rotl_strb(bus.req_strb, req_off);
  assign acc           = bus.req_valid && rdy;
  assign bus.req_ready = rdy;

  logic  vld_p0, err_p0, we_p0;
  off_t  off_p0;
  logic  cur_act, cur_we;
  word_t cur_w;
  data_t cur_wdata;
  strb_t cur_strb, cur_lanes;

`ifdef DMEM_MISALIGN_EN
  typedef enum logic {IDLE, BEAT2} state_t;
  state_t state;
  word_t  w_q;
  data_t  wdata_q;
  strb_t  strb_q;

  assign req_err = req_oor;
  assign split   = (req_off != '0) && !req_oor;
  assign beat2   = (state == BEAT2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
    end else if (state == BEAT2) begin
      state <= IDLE;
      rdy   <= 1'b1;
    end else if (acc && split) begin
      state <= BEAT2;
      rdy   <= 1'b0;
    end else begin
      rdy   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      w_q     <= req_w;
      wdata_q <= req_wdata_rot;
      strb_q  <= req_strb_rot;
    end
  end
`else
  assign req_err = req_oor || (req_off != '0);
  assign split   = 1'b0;
  assign beat2   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy <= 1'b0;
    else        rdy <= 1'b1;
  end
`endif

  // Beat 1 touches lanes >= off of word w; beat 2 touches lanes < off of word w+1.
  always_comb begin
    cur_act   = acc && !req_err;
    cur_we    = bus.req_we;
    cur_w     = req_w;
    cur_wdata = req_wdata_rot;
    cur_strb  = req_strb_rot;
    cur_lanes = lanes_from(req_off);
`ifdef DMEM_MISALIGN_EN
    if (beat2) begin
      cur_act   = 1'b1;
      cur_we    = we_p0;
      cur_w     = w_q + word_t'(1);
      cur_wdata = wdata_q;
      cur_strb  = strb_q;
      cur_lanes = ~lanes_from(off_p0);
    end
`endif
  end

  // ---- stage p0: bank access / response control ----
  data_t rd_word_p0;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [7:0] ram [DEPTH];
    logic [7:0] rd_p0;
    always_ff @(posedge clk) begin
      if (cur_act && cur_we && cur_strb[b] && cur_lanes[b])
        ram[cur_w[DW-1:0]] <= cur_wdata[b*8 +: 8];
      if (cur_act && !cur_we && cur_lanes[b])
        rd_p0 <= ram[cur_w[DW-1:0]];
    end
    assign rd_word_p0[b*8 +: 8] = rd_p0;
  end

  // we/off are held through BEAT2 since no request is accepted then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      err_p0 <= 1'b0;
      we_p0  <= 1'b0;
      off_p0 <= '0;
    end else begin
      vld_p0 <= (acc && !split) || beat2;
      err_p0 <= acc && req_err;
      if (acc) begin
        we_p0  <= bus.req_we;
        off_p0 <= req_off;
      end
    end
  end

  data_t rdata_s0;
  assign rdata_s0 = (vld_p0 && !err_p0 && !we_p0) ? rotr_data(rd_word_p0, off_p0) : '0;

  // ---- stage p1: optional response register ----
  if (RD_PIPE == 0) begin : g_rsp0
    assign bus.rsp_valid = vld_p0;
    assign bus.rsp_err   = vld_p0 && err_p0;
    assign bus.rsp_rdata = rdata_s0;
  end else begin : g_rsp1
    logic  vld_p1, err_p1;
    data_t rdata_p1;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p1 <= 1'b0;
        err_p1 <= 1'b0;
      end else begin
        vld_p1 <= vld_p0;
        err_p1 <= vld_p0 && err_p0;
      end
    end
    always_ff @(posedge clk) rdata_p1 <= rdata_s0;
    assign bus.rsp_valid = vld_p1;
    assign bus.rsp_err   = err_p1;
    assign bus.rsp_rdata = vld_p1 ? rdata_p1 : '0;
  end
endmodule

// File: tb/tb_dmem_banked.sv
// Scoreboard bench for dmem_banked: two instances (RD_PIPE 0 and 1) share one request stream.
module tb_dmem_banked;
  localparam int NB = 4;
  localparam int MEM_BYTES = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   busy_cyc = -1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] ref_mem [MEM_BYTES];

  dmem_banked_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus0 ();
  dmem_banked_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus1 ();

  assign bus1.req_valid = bus0.req_valid;
  assign bus1.req_we    = bus0.req_we;
  assign bus1.req_addr  = bus0.req_addr;
  assign bus1.req_wdata = bus0.req_wdata;
  assign bus1.req_strb  = bus0.req_strb;

  dmem_banked #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .MEM_BYTES(MEM_BYTES), .RD_PIPE(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dmem_banked #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .MEM_BYTES(MEM_BYTES), .RD_PIPE(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural model: byte i of the access is address addr+i, range/alignment rules give the error.
  function automatic void model_req(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                                    input logic [3:0] st, input int n);
    exp_t e;
    int   a;
    bit   err, split;
    int   extra;
    a     = int'(addr);
    split = (a % NB) != 0;
    err   = (a + NB - 1) >= MEM_BYTES;
`ifndef DMEM_MISALIGN_EN
    if (split) err = 1'b1;
`endif
    e.rdata = '0;
    e.err   = err;
    if (!err) begin
      for (int i = 0; i < NB; i++) begin
        if (we && st[i]) ref_mem[a+i] = wd[i*8 +: 8];
        if (!we) e.rdata[i*8 +: 8] = ref_mem[a+i];
      end
    end
    extra = (split && !err) ? 1 : 0;
    if (extra == 1) busy_cyc = n + 1;
    e.cyc = (split && err) ? -1 : n + 1 + extra;
`ifndef DMEM_MISALIGN_EN
    e.cyc = n + 1;
`endif
    q0.push_back(e);
    if (e.cyc >= 0) e.cyc = e.cyc + 1;
    q1.push_back(e);
  endfunction

  task automatic issue(input logic we, input logic [11:0] addr, input logic [31:0] wd, input logic [3:0] st);
    bit done;
    done = 1'b0;
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wd;
    bus0.req_strb  = st;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      chk("req_ready0", {31'd0, bus0.req_ready}, {31'd0, cyc != busy_cyc});
      chk("req_ready1", {31'd0, bus1.req_ready}, {31'd0, cyc != busy_cyc});
      if (bus0.req_ready) begin
        model_req(we, addr, wd, st, cyc);
        done = 1'b1;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: got no acceptance, expected one within 8 cycles (addr 0x%0h)", addr);
    end
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rsp_valid0", {31'd0, bus0.rsp_valid}, 32'd0);
    chk("rst_rsp_err0",   {31'd0, bus0.rsp_err},   32'd0);
    chk("rst_rsp_rdata0", bus0.rsp_rdata,          32'd0);
    chk("rst_req_ready0", {31'd0, bus0.req_ready}, 32'd0);
    chk("rst_rsp_valid1", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("rst_rsp_err1",   {31'd0, bus1.rsp_err},   32'd0);
    chk("rst_rsp_rdata1", bus1.rsp_rdata,          32'd0);
    chk("rst_req_ready1", {31'd0, bus1.req_ready}, 32'd0);
  endtask

  // Response monitors: pop on every rsp_valid, flag late or unexpected responses.
  exp_t m0, m1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (q0.size() > 0 && q0[0].cyc >= 0 && q0[0].cyc < cyc) begin
        m0 = q0.pop_front();
        chk("rsp0_missing_at_cycle", 32'(m0.cyc), 32'(cyc));
      end
      if (bus0.rsp_valid) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
        else begin
          m0 = q0.pop_front();
          chk("rsp0_rdata", bus0.rsp_rdata, m0.rdata);
          chk("rsp0_err", {31'd0, bus0.rsp_err}, {31'd0, m0.err});
          if (m0.cyc >= 0) chk("rsp0_cycle", 32'(cyc), 32'(m0.cyc));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (q1.size() > 0 && q1[0].cyc >= 0 && q1[0].cyc < cyc) begin
        m1 = q1.pop_front();
        chk("rsp1_missing_at_cycle", 32'(m1.cyc), 32'(cyc));
      end
      if (bus1.rsp_valid) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
        else begin
          m1 = q1.pop_front();
          chk("rsp1_rdata", bus1.rsp_rdata, m1.rdata);
          chk("rsp1_err", {31'd0, bus1.rsp_err}, {31'd0, m1.err});
          if (m1.cyc >= 0) chk("rsp1_cycle", 32'(cyc), 32'(m1.cyc));
        end
      end
    end
  end

  initial begin
    int a;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus0.req_strb  = '0;

    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", {31'd0, bus0.req_ready}, 32'd0);
    idle(1);

    // Fill every word so later reads compare against known contents.
    for (int w = 0; w < MEM_BYTES / NB; w++) issue(1'b1, 12'(w * NB), $urandom, 4'hF);

    // Aligned round trip, partial strobe, zero strobe.
    issue(1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 12'h010, 32'h0, 4'h0);
    issue(1'b1, 12'h020, 32'hAAAAAAAA, 4'hF);
    issue(1'b1, 12'h020, 32'h11223344, 4'b0101);
    issue(1'b0, 12'h020, 32'h0, 4'h0);
    issue(1'b1, 12'h030, 32'h55667788, 4'h0);
    issue(1'b0, 12'h030, 32'h0, 4'h0);
    idle(2);

    // Misaligned write then the words on either side.
    issue(1'b1, 12'h013, 32'h01020304, 4'hF);
    issue(1'b0, 12'h013, 32'h0, 4'h0);
    issue(1'b0, 12'h010, 32'h0, 4'h0);
    issue(1'b0, 12'h014, 32'h0, 4'h0);
    idle(2);

    // Top of memory and back-to-back aligned reads.
    issue(1'b0, 12'hFFC, 32'h0, 4'h0);
    issue(1'b0, 12'hFFD, 32'h0, 4'h0);
    issue(1'b1, 12'hFFE, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 4; i++) issue(1'b0, 12'(12'h100 + i * 4), 32'h0, 4'h0);
    idle(3);

    // Randomised mix of aligned and misaligned traffic with gaps.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) a = $urandom_range(0, MEM_BYTES / NB - 1) * NB;
      else a = $urandom_range(0, MEM_BYTES - 1);
      issue(1'($urandom_range(0, 1)), 12'(a), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    // Reset in the cycle after a misaligned write is accepted.
    bus0.req_valid = 1'b1;
    bus0.req_we    = 1'b1;
    bus0.req_addr  = 12'h013;
    bus0.req_wdata = 32'hA5B6C7D8;
    bus0.req_strb  = 4'hF;
    @(negedge clk);
    chk("ready_before_abort", {31'd0, bus0.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    busy_cyc = -1;
`ifdef DMEM_MISALIGN_EN
    ref_mem[12'h013] = 8'hD8;
`endif
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    issue(1'b0, 12'h010, 32'h0, 4'h0);
    issue(1'b0, 12'h014, 32'h0, 4'h0);
    idle(4);

    chk("queue0_drained", 32'(q0.size()), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
